// File: rtl/operand_swap_stage.sv
// Posit operand pre-stage: negates posit2 for subtraction, orders add/sub operands by
// magnitude, flags NaR/zero, and registers the result behind a one-entry valid/ready slot.
module operand_swap_stage #(
  parameter int N       = 16,
  parameter int OP_SIZE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       posit1,
  input  logic [N-1:0]       posit2,
  input  logic [OP_SIZE-1:0] op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_posit_a,
  output logic [N-1:0]       out_posit_b,
  output logic [OP_SIZE-1:0] out_op,
  output logic               out_sign_a,
  output logic               out_sign_b,
  output logic               out_swapped,
  output logic               out_nar,
  output logic [1:0]         out_zero
);

  localparam logic [N-1:0]       NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(1);

  logic [N-1:0] b_eff;
  logic [N-1:0] mag1;
  logic [N-1:0] mag2;
  logic [N-1:0] a_nxt;
  logic [N-1:0] b_nxt;
  logic         add_sub;
  logic         swap;
  logic         accept;

  // Two's-complement negation maps NaR to NaR, so NaR's magnitude is 2^(N-1) unsigned.
  always_comb begin
    add_sub = (op == OP_ADD) || (op == OP_SUB);
    b_eff   = (op == OP_SUB) ? -posit2 : posit2;
    mag1    = posit1[N-1] ? -posit1 : posit1;
    mag2    = b_eff[N-1] ? -b_eff : b_eff;
    swap    = add_sub && (mag2 > mag1);
    a_nxt   = swap ? b_eff : posit1;
    b_nxt   = swap ? posit1 : b_eff;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_posit_a <= '0;
      out_posit_b <= '0;
      out_op      <= '0;
      out_sign_a  <= 1'b0;
      out_sign_b  <= 1'b0;
      out_swapped <= 1'b0;
      out_nar     <= 1'b0;
      out_zero    <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_posit_a <= a_nxt;
      out_posit_b <= b_nxt;
      out_op      <= op;
      out_sign_a  <= a_nxt[N-1];
      out_sign_b  <= b_nxt[N-1];
      out_swapped <= swap;
      out_nar     <= (a_nxt == NAR) || (b_nxt == NAR);
      out_zero    <= {b_nxt == '0, a_nxt == '0};
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
